// File: rtl/popcount_window_seq_if.sv
// popcount_window_seq_if
//   Handshake and data bundle for popcount_window_seq.
//   WIDTH must match the WIDTH of the attached popcount_window_seq.
//   Signals:
//     in_valid  - word/lo/hi presented by the producer
//     in_ready  - block can accept a word (idle)
//     in_data   - WIDTH-bit word to test
//     lo, hi    - inclusive popcount window, CW bits each
//     out_valid - result available
//     out_ready - consumer takes the result
//     o         - 1 iff lo <= popcount(in_data) <= hi
//   Modports: master = producer/consumer side, slave = popcount block.
interface popcount_window_seq_if #(
   parameter int WIDTH = 16
);
   localparam int CW = $clog2(WIDTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [CW-1:0]    lo;
   logic [CW-1:0]    hi;
   logic             out_valid;
   logic             out_ready;
   logic             o;

   modport master (
      output in_valid, in_data, lo, hi, out_ready,
      input  in_ready, out_valid, o
   );

   modport slave (
      input  in_valid, in_data, lo, hi, out_ready,
      output in_ready, out_valid, o
   );
endinterface

// File: rtl/popcount_window_seq.sv
// popcount_window_seq
//   Bit-serial popcount range detector. Counts the set bits of a WIDTH-bit
//   word CHUNK bits per clock and flags whether the count lies in the
//   inclusive window [lo, hi]. The last chunk is zero-padded.
//   Ports:
//     clk  - single clock, everything on posedge
//     rst  - synchronous, active-high reset; aborts a word mid-count
//     bus  - popcount_window_seq_if.slave (in_valid/in_ready/in_data/lo/hi,
//            out_valid/out_ready/o)
//     count (only with POPCNT_COUNT_OUT_EN defined) - final popcount, CW bits,
//            valid alongside out_valid and held through DONE
//   Optional feature macro: POPCNT_COUNT_OUT_EN
//   Latency: accept at edge k -> out_valid after edge k+NB.
module popcount_window_seq #(
   parameter  int WIDTH = 16,
   parameter  int CHUNK = 4,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   popcount_window_seq_if.slave bus
`ifdef POPCNT_COUNT_OUT_EN
   ,
   output logic [CW-1:0]        count
`endif
);
   localparam int NB = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int SW = NB * CHUNK;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t        state;
   logic [SW-1:0] shreg;
   logic [CW-1:0] acc;
   logic [CW-1:0] lo_r;
   logic [CW-1:0] hi_r;
   logic [BW-1:0] beat;
   logic [CW-1:0] chunk_cnt;
   logic [CW-1:0] sum;
   logic          in_ready_r;
   logic          out_valid_r;
   logic          o_r;

   // Popcount of the low chunk plus the running total; never exceeds WIDTH.
   always_comb begin
      chunk_cnt = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         chunk_cnt = chunk_cnt + CW'(shreg[i]);
      end
      sum = acc + chunk_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         o_r         <= 1'b0;
         acc         <= '0;
         beat        <= '0;
         shreg       <= '0;
         lo_r        <= '0;
         hi_r        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  // Zero-extension pads the final partial chunk.
                  shreg      <= SW'(bus.in_data);
                  lo_r       <= bus.lo;
                  hi_r       <= bus.hi;
                  acc        <= '0;
                  beat       <= '0;
                  in_ready_r <= 1'b0;
                  state      <= COUNT;
               end
            end
            COUNT: begin
               acc   <= sum;
               shreg <= shreg >> CHUNK;
               beat  <= beat + 1'b1;
               if (beat == BW'(NB - 1)) begin
                  // Decision taken from the final sum on the last add's edge.
                  o_r         <= (sum >= lo_r) && (sum <= hi_r);
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.o         = o_r;

`ifdef POPCNT_COUNT_OUT_EN
   // acc holds the final sum from the last beat until the next word is accepted.
   assign count = acc;
`endif
endmodule
